ifmap_buffer_ctrl: RTL and testbench

//  Sequencer for the ifmap double buffer (one write bank, one read bank, bank swap on switch_banks pulse).

---
 rtl/ifmap_buffer_ctrl.sv | 138 +++++++++++++
 tb/tb_ifmap_buffer_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_buffer_ctrl.sv
// Sequencer for the ifmap double buffer: fills the write bank from a valid/ready stream and
// replays the read bank cfg_passes times through a 2-entry output FIFO.
module ifmap_buffer_ctrl #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned BANK_ADDR_WIDTH = 3,
  parameter int unsigned BANK_DEPTH      = 8,
  parameter int unsigned PASS_WIDTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [PASS_WIDTH-1:0]      cfg_passes_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_WIDTH-1:0]      in_data_i,
  input  logic                       in_last_i,
  output logic                       wen_o,
  output logic [BANK_ADDR_WIDTH-1:0] wadr_o,
  output logic [DATA_WIDTH-1:0]      wdata_o,
  output logic                       ren_o,
  output logic [BANK_ADDR_WIDTH-1:0] radr_o,
  input  logic [DATA_WIDTH-1:0]      rdata_i,
  output logic                       switch_banks_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_data_o
);

  localparam int unsigned LenW = BANK_ADDR_WIDTH + 1;

  typedef enum logic {StFilling, StFull} wr_st_e;
  typedef enum logic [1:0] {StIdle, StActive, StDone} rd_st_e;

  wr_st_e                     wr_st_q;
  logic [BANK_ADDR_WIDTH-1:0] wr_cnt_q;
  logic [LenW-1:0]            wr_len_q;
  rd_st_e                     rd_st_q;
  logic [BANK_ADDR_WIDTH-1:0] rd_ptr_q;
  logic [LenW-1:0]            rd_len_q;
  logic [PASS_WIDTH-1:0]      pass_q;
  logic [PASS_WIDTH-1:0]      passes_q;
  logic                       inflight_q;
  logic [DATA_WIDTH-1:0]      fifo_q [2];
  logic                       head_q;
  logic                       tail_q;
  logic [1:0]                 fifo_cnt_q;

  logic                  wr_full, rd_loaded, rd_done, rd_active;
  logic                  wr_last, rd_last, pop, push;
  logic [2:0]            credit_used;
  logic [PASS_WIDTH-1:0] passes_eff;

  always_comb begin
    wr_full     = (wr_st_q == StFull);
    rd_loaded   = (rd_st_q != StIdle);
    rd_done     = (rd_st_q == StDone);
    rd_active   = (rd_st_q == StActive);
    in_ready_o  = !wr_full && !rst_i;
    wen_o       = in_valid_i && in_ready_o;
    wadr_o      = wr_cnt_q;
    wdata_o     = in_data_i;
    out_valid_o = (fifo_cnt_q != 2'd0);
    out_data_o  = fifo_q[head_q];
    pop         = out_valid_o && out_ready_i;
    push        = inflight_q;
    // Words already held or on their way, less the one leaving this cycle.
    credit_used = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    ren_o       = rd_active && (credit_used < 3'd2);
    radr_o      = rd_ptr_q;
    switch_banks_o = wr_full && (!rd_loaded || rd_done) && !inflight_q;
    wr_last     = (wr_cnt_q == BANK_ADDR_WIDTH'(BANK_DEPTH - 1));
    rd_last     = ({1'b0, rd_ptr_q} == rd_len_q - LenW'(1));
    passes_eff  = (cfg_passes_i == '0) ? PASS_WIDTH'(1) : cfg_passes_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_st_q    <= StFilling;
      wr_cnt_q   <= '0;
      wr_len_q   <= '0;
      rd_st_q    <= StIdle;
      rd_ptr_q   <= '0;
      rd_len_q   <= '0;
      pass_q     <= '0;
      passes_q   <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (switch_banks_o) begin
        wr_st_q  <= StFilling;
        wr_cnt_q <= '0;
        rd_st_q  <= StActive;
        rd_len_q <= wr_len_q;
        passes_q <= passes_eff;
        rd_ptr_q <= '0;
        pass_q   <= '0;
      end else begin
        if (wen_o) begin
          if (in_last_i || wr_last) begin
            wr_st_q  <= StFull;
            wr_len_q <= LenW'(wr_cnt_q) + LenW'(1);
          end else begin
            wr_cnt_q <= wr_cnt_q + BANK_ADDR_WIDTH'(1);
          end
        end
        if (ren_o) begin
          if (rd_last) begin
            rd_ptr_q <= '0;
            pass_q   <= pass_q + PASS_WIDTH'(1);
            if (pass_q == passes_q - PASS_WIDTH'(1)) begin
              rd_st_q <= StDone;
            end
          end else begin
            rd_ptr_q <= rd_ptr_q + BANK_ADDR_WIDTH'(1);
          end
        end
      end
      // Buffer returns data one cycle after ren; the credit rule keeps room for it.
      inflight_q <= ren_o;
      if (push) begin
        fifo_q[tail_q] <= rdata_i;
        tail_q         <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_buffer_ctrl.sv
// Self-checking bench for ifmap_buffer_ctrl with a behavioural double-buffer model.
module tb_ifmap_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_passes;
  logic        in_valid, in_ready, in_last;
  logic [63:0] in_data;
  logic        wen, ren, switch_banks, out_valid, out_ready;
  logic [2:0]  wadr, radr;
  logic [63:0] wdata, rdata, out_data;

  logic rand_rdy = 1'b0;
  logic rdy_force = 1'b1;
  logic rnd_bit = 1'b1;
  assign out_ready = rand_rdy ? rnd_bit : rdy_force;

  always #5 clk = ~clk;

  ifmap_buffer_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cfg_passes_i(cfg_passes),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .wen_o(wen), .wadr_o(wadr), .wdata_o(wdata),
    .ren_o(ren), .radr_o(radr), .rdata_i(rdata),
    .switch_banks_o(switch_banks),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
  );

  // Double-buffer model: write bank and read bank swap on switch_banks.
  logic [63:0] bmem [2][8];
  logic        wbank = 1'b0;
  always @(posedge clk) begin
    if (wen) bmem[wbank][wadr] <= wdata;
    if (ren) rdata <= bmem[~wbank][radr];
    if (switch_banks) wbank <= ~wbank;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: records accepted output words, switch pulses and read issues.
  logic [63:0] recv_q[$];
  int          recv_cyc_q[$];
  int          sw_cyc_q[$];
  int          sw_ren_q[$];
  int          cyc = 0;
  int          ren_total = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        recv_q.push_back(out_data);
        recv_cyc_q.push_back(cyc);
      end
      if (switch_banks) begin
        sw_cyc_q.push_back(cyc);
        sw_ren_q.push_back(ren_total);
      end
      if (ren) ren_total <= ren_total + 1;
      if (stall_prev) begin
        chk("stall out_valid", {63'd0, out_valid}, 64'd1);
        chk("stall out_data", out_data, prev_data);
      end
      stall_prev <= out_valid && !out_ready;
      prev_data  <= out_data;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_tile(input logic [63:0] base, input logic [63:0] mult, input int n);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + mult * 64'(i);
      in_last  = (i == n - 1);
      acc = 1'b0;
      t = 0;
      while (!acc && t < 400) begin
        @(negedge clk);
        acc = in_ready;
        tick();
        t++;
      end
      chk("write accepted", {63'd0, acc}, 64'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_recv(input int n);
    int t;
    t = 0;
    while (recv_q.size() < n && t < 500) begin
      tick();
      t++;
    end
    chk("output count reached", 64'(recv_q.size() >= n), 64'd1);
  endtask

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        il;
    logic        e_rdy;
    logic        e_wen;
    logic [2:0]  e_wadr;
    logic        e_ren;
    logic [2:0]  e_radr;
    logic        e_sw;
    logic        e_ov;
    logic [63:0] e_od;
  } vec_t;

  vec_t vt [10];

  initial begin : main
    int rb, sb, rnb, s, t;
    bit seen_rdy;

    // Partial tile 5,6,7 (in_last on word 2), one pass, consumer always ready.
    vt[0] = '{1'b1, 64'd5, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0};
    vt[1] = '{1'b1, 64'd6, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0};
    vt[2] = '{1'b1, 64'd7, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0};
    vt[3] = '{1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 64'd0};
    vt[4] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 64'd0};
    vt[5] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0, 64'd0};
    vt[6] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1, 64'd5};
    vt[7] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd6};
    vt[8] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd7};
    vt[9] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0};

    cfg_passes = 4'd1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;

    // Reset state.
    tick();
    tick();
    @(negedge clk);
    chk("rst in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst wen", {63'd0, wen}, 64'd0);
    chk("rst ren", {63'd0, ren}, 64'd0);
    chk("rst switch", {63'd0, switch_banks}, 64'd0);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst wadr", {61'd0, wadr}, 64'd0);
    chk("rst radr", {61'd0, radr}, 64'd0);
    chk("rst out_data", out_data, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("post-rst switch", {63'd0, switch_banks}, 64'd0);
    tick();

    // Table: partial tile, cycle by cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].id; in_last = vt[i].il;
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, {63'd0, vt[i].e_rdy});
      chk($sformatf("vec%0d wen", i), {63'd0, wen}, {63'd0, vt[i].e_wen});
      if (vt[i].e_wen) chk($sformatf("vec%0d wadr", i), {61'd0, wadr}, {61'd0, vt[i].e_wadr});
      chk($sformatf("vec%0d ren", i), {63'd0, ren}, {63'd0, vt[i].e_ren});
      if (vt[i].e_ren) chk($sformatf("vec%0d radr", i), {61'd0, radr}, {61'd0, vt[i].e_radr});
      chk($sformatf("vec%0d switch", i), {63'd0, switch_banks}, {63'd0, vt[i].e_sw});
      chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].e_ov});
      if (vt[i].e_ov) chk($sformatf("vec%0d out_data", i), out_data, vt[i].e_od);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;

    // Full tile, one pass: one switch at S, outputs at S+3.. back to back.
    do_reset();
    rb = recv_q.size(); sb = sw_cyc_q.size();
    write_tile(64'd0, 64'd1, 8);
    wait_recv(rb + 8);
    repeat (5) tick();
    chk("t2 switch count", 64'(sw_cyc_q.size() - sb), 64'd1);
    chk("t2 recv count", 64'(recv_q.size() - rb), 64'd8);
    s = (sw_cyc_q.size() > sb) ? sw_cyc_q[sb] : 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2 data%0d", i), recv_q[rb + i], 64'(i));
      chk($sformatf("t2 cycle%0d", i), 64'(recv_cyc_q[rb + i]), 64'(s + 3 + i));
    end

    // Tile B streamed while A is read; second switch only after all A reads.
    do_reset();
    rb = recv_q.size(); sb = sw_cyc_q.size(); rnb = ren_total;
    write_tile(64'd0, 64'd1, 8);
    write_tile(64'd0, 64'h10, 8);
    wait_recv(rb + 16);
    repeat (5) tick();
    chk("t3 switch count", 64'(sw_cyc_q.size() - sb), 64'd2);
    chk("t3 recv count", 64'(recv_q.size() - rb), 64'd16);
    if (sw_ren_q.size() >= sb + 2)
      chk("t3 reads before 2nd switch", 64'(sw_ren_q[sb + 1] - rnb), 64'd8);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t3 data%0d", i), recv_q[rb + i], (i < 8) ? 64'(i) : 64'(16 * (i - 8)));

    // Three passes; next tile waits for the third pass; then passes=0 acts as 1.
    do_reset();
    cfg_passes = 4'd3;
    rb = recv_q.size(); sb = sw_cyc_q.size(); rnb = ren_total;
    write_tile(64'd0, 64'd1, 8);
    write_tile(64'h40, 64'd1, 8);
    cfg_passes = 4'd0;
    @(negedge clk);
    chk("t5 in_ready low while full", {63'd0, in_ready}, 64'd0);
    t = 0; seen_rdy = 1'b0;
    while (!seen_rdy && t < 300) begin
      tick();
      @(negedge clk);
      seen_rdy = in_ready;
      t++;
    end
    chk("t5 switches when in_ready returns", 64'(sw_cyc_q.size() - sb), 64'd2);
    wait_recv(rb + 32);
    repeat (10) tick();
    chk("t5 recv count", 64'(recv_q.size() - rb), 64'd32);
    if (sw_ren_q.size() >= sb + 2)
      chk("t5 reads before 2nd switch", 64'(sw_ren_q[sb + 1] - rnb), 64'd24);
    for (int i = 0; i < 32; i++)
      chk($sformatf("t5 data%0d", i), recv_q[rb + i], (i < 24) ? 64'(i % 8) : 64'h40 + 64'(i - 24));
    cfg_passes = 4'd1;

    // Back-pressure: 5 stalled cycles then random ready.
    do_reset();
    rb = recv_q.size();
    write_tile(64'h50, 64'd1, 8);
    wait_recv(rb + 3);
    rdy_force = 1'b0;
    repeat (5) tick();
    rand_rdy = 1'b1;
    wait_recv(rb + 8);
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    repeat (5) tick();
    chk("t6 recv count", 64'(recv_q.size() - rb), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t6 data%0d", i), recv_q[rb + i], 64'h50 + 64'(i));

    // Reset mid-stream, then a fresh tile.
    rb = recv_q.size();
    write_tile(64'h30, 64'd1, 8);
    wait_recv(rb + 2);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("mid-rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid-rst ren", {63'd0, ren}, 64'd0);
    chk("mid-rst switch", {63'd0, switch_banks}, 64'd0);
    chk("mid-rst in_ready", {63'd0, in_ready}, 64'd0);
    chk("mid-rst out_data", out_data, 64'd0);
    tick();
    rst = 1'b0;
    rb = recv_q.size();
    write_tile(64'h20, 64'd1, 8);
    wait_recv(rb + 8);
    repeat (5) tick();
    chk("t6 fresh recv count", 64'(recv_q.size() - rb), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t6 fresh data%0d", i), recv_q[rb + i], 64'h20 + 64'(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
